// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-state encoding, default widths and pc increment
package cpu_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_PC_INC = 4;
    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} fetch_state_t;
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction
endpackage

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetches the word at pc over req/ack, buffers it for decode, drives pc write-back
// ports: clk/rst (sync, active-high); pc in; pc_write/pc_write_value out;
//        redirect/redirect_target in; imem_req/imem_addr out, imem_ack/imem_rdata in;
//        inst_valid/inst/inst_pc out, inst_ready in; fetch_fault out (sticky until redirect)
module imem_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int PC_INC = DEF_PC_INC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_write,
    output logic [ADDR_W-1:0] pc_write_value,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fetch_fault
);
    fetch_state_t      r_state, w_next;
    logic              r_kill, r_imem_req, r_inst_valid, r_fault;
    logic [ADDR_W-1:0] r_imem_addr, r_inst_pc;
    logic [DATA_W-1:0] r_inst;
    logic              w_redir, w_ack, w_ack_ok, w_enter;
    logic [ADDR_W-1:0] w_fetch_pc;

    assign w_redir  = redirect && r_state != IDLE;
    assign w_ack    = r_state == REQ && imem_ack;
    assign w_ack_ok = w_ack && !r_kill && !w_redir;
    // a redirect's pc_write only lands next cycle, so fetch from the target directly
    assign w_fetch_pc = w_redir ? redirect_target : pc;

    always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;

    always_comb begin
        w_enter = 1'b0;
        w_next  = r_state;
        case (r_state)
            IDLE:  w_enter = 1'b1;
            REQ:   begin
                w_enter = w_ack && !w_ack_ok;
                if (w_ack_ok) w_next = HOLD;
            end
            HOLD:  w_enter = w_redir || inst_ready;
            FAULT: w_enter = w_redir;
        endcase
        if (w_enter) w_next = misaligned(w_fetch_pc[1:0]) ? FAULT : REQ;
    end

    always_comb begin
        pc_write       = w_redir || w_ack_ok;
        pc_write_value = w_redir ? redirect_target : w_ack_ok ? r_imem_addr + ADDR_W'(PC_INC) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kill       <= 1'b0;
            r_imem_req   <= 1'b0;
            r_imem_addr  <= '0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_fault      <= 1'b0;
        end else begin
            // kill marks the in-flight request as stale until its ack drains it
            r_kill <= r_state == REQ && !imem_ack && (r_kill || w_redir);
            if (w_enter) begin
                r_imem_req <= w_next == REQ;
                if (w_next == REQ) r_imem_addr <= w_fetch_pc;
            end else if (w_ack) begin
                r_imem_req <= 1'b0;
            end
            if (w_ack_ok) begin
                r_inst       <= imem_rdata;
                r_inst_pc    <= r_imem_addr;
                r_inst_valid <= 1'b1;
            end else if (r_state == HOLD && w_enter) begin
                r_inst_valid <= 1'b0;
            end
            r_fault <= w_next == FAULT;
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign inst_valid  = r_inst_valid;
    assign inst        = r_inst;
    assign inst_pc     = r_inst_pc;
    assign fetch_fault = r_fault;
endmodule
